// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
// Programming front end for the fabric configuration chain. Configuration
// words arrive on a valid/ready stream and are serialized MSB-first onto
// ccff_head, one shift-enable per bit. After exactly CHAIN_LEN shifts the
// tail of the chain is compared against the first bit of the pass.
//
// Output timing:
// - ccff_head, ccff_shift_en, bit_count and error are registered.
// - word_ready, busy and done decode the state register.
// - The head/shift-enable pair is loaded on the same edge that enters or
//   stays in SHIFT, so ccff_shift_en is high exactly while state == SHIFT.
// - bit_count advances on the same edge that shifts the chain, so it always
//   counts bits already clocked into the chain.

module ccff_bitstream_loader #(
  parameter int WORD_W    = 8,   // width of each incoming bitstream word
  parameter int CHAIN_LEN = 64,  // number of configuration flops, >= 1
  parameter int CNT_W     = 16   // bit counter width, 2**CNT_W > CHAIN_LEN
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);

  // Wide enough to hold WORD_W itself, not just WORD_W-1.
  localparam int BL_W = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0] CHAIN_LEN_C  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_COUNT_C = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] WORD_W_C     = CNT_W'(WORD_W);
  localparam logic [BL_W-1:0]  ONE_BL       = BL_W'(1);
  localparam logic [CNT_W-1:0] ONE_CNT      = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state;
  state_t next_state;

  // Word currently being serialized. The bit on ccff_head has already been
  // removed, so shreg[WORD_W-1] is always the next bit to present.
  logic [WORD_W-1:0] shreg;

  // Bits of the current word still to be clocked into the chain,
  // including the one on ccff_head.
  logic [BL_W-1:0] bits_left;

  // First bit of the pass. After CHAIN_LEN shifts it should reach the tail.
  logic first_bit;

  // Derived control.
  logic             start_pass;
  logic             accept;
  logic             last_bit;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] load_len;

  // Decode handshake and per-word length from state and counters.
  // NOTE: every signal driven from always_comb is assigned a default first, so
  // no path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    start_pass = 1'b0;
    accept     = 1'b0;
    last_bit   = 1'b0;
    remaining  = CHAIN_LEN_C - bit_count;
    load_len   = WORD_W_C;

    // A final partial word only contributes the bits the chain still needs.
    if (remaining < WORD_W_C) begin
      load_len = remaining;
    end

    start_pass = start && ((state == S_IDLE) || (state == S_DONE));
    accept     = word_valid && (state == S_LOAD);
    last_bit   = (state == S_SHIFT) && (bits_left == ONE_BL);
  end

  // Next-state logic.
  always_comb begin
    next_state = state;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_LOAD;
        end
      end

      S_LOAD: begin
        // Waits indefinitely for the next word. There is no timeout.
        if (word_valid) begin
          next_state = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (bits_left == ONE_BL) begin
          // bit_count has not yet counted the bit shifting on this edge.
          if (bit_count == LAST_COUNT_C) begin
            next_state = S_CHECK;
          end else begin
            next_state = S_LOAD;
          end
        end
      end

      S_CHECK: begin
        next_state = S_DONE;
      end

      S_DONE: begin
        if (start) begin
          next_state = S_LOAD;
        end
      end

      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Outputs decoded directly from the state register.
  always_comb begin
    word_ready = (state == S_LOAD);
    busy       = (state != S_IDLE) && (state != S_DONE);
    done       = (state == S_DONE);
  end

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of the order of the processes.
  always_ff @(posedge CK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Datapath: serializer, counters, chain drive and tail check.
  // The serializer state is cleared on reset, so an abandoned pass cannot
  // leak stale bits into the next one.
  always_ff @(posedge CK) begin
    if (RST) begin
      shreg         <= '0;
      bits_left     <= '0;
      first_bit     <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      bit_count     <= '0;
      error         <= 1'b0;
    end else begin
      if (start_pass) begin
        bit_count <= '0;
        error     <= 1'b0;
      end

      if (accept) begin
        // Present the MSB at once, so the first shift happens on the next edge.
        shreg         <= word_data << 1;
        bits_left     <= BL_W'(load_len);
        ccff_head     <= word_data[WORD_W-1];
        ccff_shift_en <= 1'b1;
      end

      if (state == S_SHIFT) begin
        // The chain captures ccff_head on this edge.
        bit_count <= bit_count + ONE_CNT;
        bits_left <= bits_left - ONE_BL;

        if (bit_count == '0) begin
          first_bit <= ccff_head;
        end

        if (last_bit) begin
          // Any unused low bits of a partial word stay in shreg and are dropped.
          ccff_head     <= 1'b0;
          ccff_shift_en <= 1'b0;
        end else begin
          ccff_head <= shreg[WORD_W-1];
          shreg     <= shreg << 1;
        end
      end

      if (state == S_CHECK) begin
        error <= (ccff_tail != first_bit);
      end
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Testbench for ccff_bitstream_loader.
// Instance a: CHAIN_LEN=20, WORD_W=8.
// Instance b: CHAIN_LEN=8,  WORD_W=8.
// Each instance drives a behavioural chain model that feeds its ccff_tail.

module tb_ccff_bitstream_loader;

  localparam int A_LEN = 20;
  localparam int B_LEN = 8;

  // Clock, reset and check counters.
  logic CK  = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Instance a signals.
  logic        a_start = 1'b0;
  logic        a_valid = 1'b0;
  logic [7:0]  a_data  = '0;
  logic        a_ready;
  logic        a_head;
  logic        a_sen;
  logic        a_tail;
  logic        a_busy;
  logic        a_done;
  logic        a_error;
  logic [15:0] a_cnt;
  logic        a_inv   = 1'b0;
  logic [A_LEN-1:0] a_chain = '0;
  logic        a_heads[$];

  // Instance b signals.
  logic        b_start = 1'b0;
  logic        b_valid = 1'b0;
  logic [7:0]  b_data  = '0;
  logic        b_ready;
  logic        b_head;
  logic        b_sen;
  logic        b_tail;
  logic        b_busy;
  logic        b_done;
  logic        b_error;
  logic [15:0] b_cnt;
  logic [B_LEN-1:0] b_chain = '0;
  logic        b_heads[$];

  always #5 CK = ~CK;

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(A_LEN), .CNT_W(16)) dut_a (
    .CK(CK), .RST(RST), .start(a_start), .word_valid(a_valid), .word_data(a_data),
    .word_ready(a_ready), .ccff_head(a_head), .ccff_shift_en(a_sen), .ccff_tail(a_tail),
    .busy(a_busy), .done(a_done), .error(a_error), .bit_count(a_cnt)
  );

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(B_LEN), .CNT_W(16)) dut_b (
    .CK(CK), .RST(RST), .start(b_start), .word_valid(b_valid), .word_data(b_data),
    .word_ready(b_ready), .ccff_head(b_head), .ccff_shift_en(b_sen), .ccff_tail(b_tail),
    .busy(b_busy), .done(b_done), .error(b_error), .bit_count(b_cnt)
  );

  // Behavioural configuration chains. a_inv corrupts a's tail on purpose.
  always @(posedge CK) begin
    if (a_sen) a_chain <= {a_chain[A_LEN-2:0], a_head};
    if (b_sen) b_chain <= {b_chain[B_LEN-2:0], b_head};
  end
  assign a_tail = a_chain[A_LEN-1] ^ a_inv;
  assign b_tail = b_chain[B_LEN-1];

  // Record every head bit the chain is about to capture.
  always @(negedge CK) begin
    if (a_sen === 1'b1) a_heads.push_back(a_head);
    if (b_sen === 1'b1) b_heads.push_back(b_head);
  end

  // ---------------- stimulus helpers ----------------

  task automatic pulse_start(input bit sel_b);
    if (sel_b) b_start = 1'b1; else a_start = 1'b1;
    @(negedge CK);
    b_start = 1'b0;
    a_start = 1'b0;
  endtask

  task automatic send_word(input bit sel_b, input logic [7:0] d);
    bit got = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if ((sel_b ? b_ready : a_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge CK);
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL word_ready_timeout: ready=0 after 100 cycles, required 1");
    end
    if (sel_b) begin b_valid = 1'b1; b_data = d; end
    else       begin a_valid = 1'b1; a_data = d; end
    @(negedge CK);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel_b);
    bit got = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if ((sel_b ? b_done : a_done) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge CK);
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL done_timeout: done=0 after 100 cycles, required 1");
    end
  endtask

  // Packs instance a's recorded head bits, first bit ending up as the MSB.
  task automatic check_a_heads(input string name, input logic [A_LEN-1:0] exp);
    logic [A_LEN-1:0] got = '0;
    foreach (a_heads[i]) got = {got[A_LEN-2:0], a_heads[i]};
    n_checks++;
    if (a_heads.size() != A_LEN) begin
      n_fail++;
      $display("FAIL %s_pulses: got %0d shift pulses, required %0d", name, a_heads.size(), A_LEN);
    end
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s_heads: got %h, required %h", name, got, exp);
    end
  endtask

  // ---------------- tests ----------------

  task automatic test_reset;
    n_checks++;
    if ({a_ready, a_head, a_sen, a_busy, a_done, a_error} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 000000",
               {a_ready, a_head, a_sen, a_busy, a_done, a_error});
    end
    n_checks++;
    if (a_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d, required 0", a_cnt);
    end
  endtask

  task automatic test_full_pass;
    a_heads.delete();
    pulse_start(1'b0);
    send_word(1'b0, 8'hA5);
    send_word(1'b0, 8'h3C);
    send_word(1'b0, 8'hF0);
    wait_done(1'b0);
    check_a_heads("full_pass", 20'hA53CF);
    n_checks++;
    if ({a_done, a_error, a_busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL full_pass_status: done/error/busy got %b, required 100", {a_done, a_error, a_busy});
    end
    n_checks++;
    if (a_cnt !== 16'd20) begin
      n_fail++;
      $display("FAIL full_pass_count: got %0d, required 20", a_cnt);
    end
  endtask

  task automatic test_tail_fail;
    a_inv = 1'b1;
    pulse_start(1'b0);
    n_checks++;
    if ({a_error, a_done, a_cnt} !== {2'b00, 16'd0}) begin
      n_fail++;
      $display("FAIL tail_fail_start: error=%b done=%b count=%0d, required 0 0 0", a_error, a_done, a_cnt);
    end
    send_word(1'b0, 8'hA5);
    send_word(1'b0, 8'h3C);
    send_word(1'b0, 8'hF0);
    wait_done(1'b0);
    n_checks++;
    if ({a_done, a_error} !== 2'b11) begin
      n_fail++;
      $display("FAIL tail_fail_error: done/error got %b, required 11", {a_done, a_error});
    end
    a_inv = 1'b0;
  endtask

  task automatic test_stall;
    int bad = 0;
    a_heads.delete();
    pulse_start(1'b0);
    // Idle in LOAD before the first word.
    for (int i = 0; i < 10; i++) begin
      if (a_ready !== 1'b1 || a_sen !== 1'b0 || a_cnt !== 16'd0) bad++;
      @(negedge CK);
    end
    send_word(1'b0, 8'hA5);
    for (int t = 0; t < 20 && a_ready !== 1'b1; t++) @(negedge CK);
    // Idle in LOAD between words.
    for (int i = 0; i < 10; i++) begin
      if (a_ready !== 1'b1 || a_sen !== 1'b0 || a_cnt !== 16'd8) bad++;
      @(negedge CK);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d stalled cycles misbehaved, required 0", bad);
    end
    send_word(1'b0, 8'h3C);
    send_word(1'b0, 8'hF0);
    wait_done(1'b0);
    check_a_heads("stall", 20'hA53CF);
    n_checks++;
    if ({a_done, a_error} !== 2'b10) begin
      n_fail++;
      $display("FAIL stall_status: done/error got %b, required 10", {a_done, a_error});
    end
  endtask

  task automatic test_ignored_inputs;
    a_heads.delete();
    pulse_start(1'b0);
    send_word(1'b0, 8'hA5);
    // Now in SHIFT: stray start and valid with a different word.
    a_start = 1'b1;
    a_valid = 1'b1;
    a_data  = 8'h00;
    repeat (3) @(negedge CK);
    a_start = 1'b0;
    a_valid = 1'b0;
    n_checks++;
    if ({a_busy, a_ready, a_sen, a_cnt} !== {3'b101, 16'd3}) begin
      n_fail++;
      $display("FAIL ignored_mid_shift: busy/ready/sen=%b count=%0d, required 101 3",
               {a_busy, a_ready, a_sen}, a_cnt);
    end
    send_word(1'b0, 8'h3C);
    send_word(1'b0, 8'hF0);
    wait_done(1'b0);
    check_a_heads("ignored", 20'hA53CF);
  endtask

  task automatic test_reset_mid_shift;
    int qsize;
    a_heads.delete();
    pulse_start(1'b0);
    send_word(1'b0, 8'hA5);
    for (int t = 0; t < 20 && a_cnt !== 16'd5; t++) @(negedge CK);
    RST = 1'b1;
    @(negedge CK);
    RST = 1'b0;
    n_checks++;
    if ({a_ready, a_head, a_sen, a_busy, a_done, a_error} !== 6'b0 || a_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %b count=%0d, required 000000 0",
               {a_ready, a_head, a_sen, a_busy, a_done, a_error}, a_cnt);
    end
    qsize = a_heads.size();
    repeat (4) @(negedge CK);
    n_checks++;
    if (a_heads.size() != qsize || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: shifts %0d->%0d busy=%b, required no shifts busy=0",
               qsize, a_heads.size(), a_busy);
    end
    a_heads.delete();
    pulse_start(1'b0);
    n_checks++;
    if ({a_busy, a_ready, a_cnt} !== {2'b11, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_restart: busy/ready=%b count=%0d, required 11 0", {a_busy, a_ready}, a_cnt);
    end
    send_word(1'b0, 8'hA5);
    send_word(1'b0, 8'h3C);
    send_word(1'b0, 8'hF0);
    wait_done(1'b0);
    check_a_heads("reset_mid", 20'hA53CF);
    n_checks++;
    if ({a_done, a_error, a_cnt} !== {2'b10, 16'd20}) begin
      n_fail++;
      $display("FAIL reset_mid_result: done/error=%b count=%0d, required 10 20", {a_done, a_error}, a_cnt);
    end
  endtask

  task automatic test_restart_from_done;
    logic [7:0] got = '0;
    // First pass brings b to DONE.
    pulse_start(1'b1);
    send_word(1'b1, 8'h81);
    wait_done(1'b1);
    n_checks++;
    if ({b_done, b_error, b_cnt} !== {2'b10, 16'd8}) begin
      n_fail++;
      $display("FAIL restart_first: done/error=%b count=%0d, required 10 8", {b_done, b_error}, b_cnt);
    end
    b_heads.delete();
    pulse_start(1'b1);
    n_checks++;
    if ({b_done, b_busy, b_cnt} !== {2'b01, 16'd0}) begin
      n_fail++;
      $display("FAIL restart_drop: done/busy=%b count=%0d, required 01 0", {b_done, b_busy}, b_cnt);
    end
    send_word(1'b1, 8'h81);
    wait_done(1'b1);
    foreach (b_heads[i]) got = {got[6:0], b_heads[i]};
    n_checks++;
    if (b_heads.size() != B_LEN || got !== 8'h81) begin
      n_fail++;
      $display("FAIL restart_heads: got %0d pulses value %h, required 8 pulses value 81",
               b_heads.size(), got);
    end
    n_checks++;
    if ({b_done, b_error, b_cnt} !== {2'b10, 16'd8}) begin
      n_fail++;
      $display("FAIL restart_result: done/error=%b count=%0d, required 10 8", {b_done, b_error}, b_cnt);
    end
  endtask

  // ---------------- sequence ----------------

  initial begin
    repeat (2) @(negedge CK);
    RST = 1'b0;
    test_reset();
    test_full_pass();
    test_tail_fail();
    test_stall();
    test_ignored_inputs();
    test_reset_mid_shift();
    test_restart_from_done();
    repeat (2) @(negedge CK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Last-resort guard against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
Bitstream loader that sits directly upstream of the configuration-chain flip-flops (the DFFR-based ccff scan chain) in the generated fabric. It accepts configuration words over a valid/ready stream and serializes them MSB-first onto ccff_head, with one shift-enable per bit. After exactly CHAIN_LEN shifts it performs a tail check on ccff_tail and reports done or error. It is the programming front end between the SoC/test host and the fabric's configuration chain.

Parameters:
WORD_W, 8, width of each incoming bitstream word
CHAIN_LEN, 64, total number of configuration flip-flops in the chain (must be >= 1)
CNT_W, 16, width of bit counter; must satisfy 2^CNT_W > CHAIN_LEN

Ports:
CK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a programming pass
word_valid  input  1  upstream word available
word_data  input  WORD_W  bitstream word, bit WORD_W-1 shifted first
word_ready  output  1  loader accepts word this cycle
ccff_head  output  1  serial data into chain head (registered)
ccff_shift_en  output  1  chain shifts at the CK edge ending a cycle where this is 1 (registered)
ccff_tail  input  1  serial output of last chain flip-flop
busy  output  1  high in any state except IDLE and DONE
done  output  1  level, high in DONE
error  output  1  level, tail-check mismatch; valid while done=1
bit_count  output  CNT_W  bits shifted so far in current pass

Behaviour:
- Reset (RST=1 at an edge, any state, including mid-shift): state=IDLE; word_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, error=0, bit_count=0; internal shift register and first_bit cleared. A partially loaded chain is abandoned; no further shifts occur.
- FSM states: IDLE, LOAD, SHIFT, CHECK, DONE.
- IDLE: start=1 -> LOAD; bit_count<=0, error<=0.
- LOAD: word_ready=1 combinationally from state (independent of word_valid). On word_valid&word_ready: latch word_data into shift register, bits_left<=min(WORD_W, CHAIN_LEN-bit_count), -> SHIFT. Without valid: remain in LOAD, ccff_shift_en=0, no timeout.
- SHIFT: each cycle, drive ccff_head=current MSB, ccff_shift_en=1, shift register left by 1, bit_count+1, bits_left-1. The first bit of the pass (bit_count=0) is also stored in first_bit. When bits_left reaches 0: if bit_count==CHAIN_LEN -> CHECK, else -> LOAD. Excess bits of a final partial word are discarded and never shifted.
- Throughput: one LOAD cycle plus WORD_W SHIFT cycles per full word. ccff_shift_en never asserts outside SHIFT.
- CHECK: one cycle, ccff_shift_en=0. Sample ccff_tail; error<=(ccff_tail!=first_bit), since after CHAIN_LEN shifts the tail flop holds the first bit shifted in. -> DONE.
- DONE: done=1, error held. start=1 -> LOAD for a new pass (bit_count and error cleared). Otherwise hold.
- start while busy: ignored. word_valid outside LOAD: ignored, with no side effects.
- bit_count never exceeds CHAIN_LEN.
- All outputs are registered except word_ready, busy and done, which decode the state register.

Test Plan:
- Reset mid-shift: CHAIN_LEN=20, WORD_W=8, RST after 5 shifts -> next cycle all outputs 0, state IDLE. A later start begins with bit_count=0.
- Full pass with partial last word: CHAIN_LEN=20, words 0xA5, 0x3C, 0xF0 -> exactly 20 ccff_shift_en pulses, head sequence 10100101 00111100 1111. The low nibble of 0xF0 is never shifted. Result: done=1, bit_count=20.
- Tail check pass/fail: behavioural 20-flop chain model feeding ccff_tail -> error=0. Force ccff_tail to be inverted during CHECK -> error=1, done=1.
- Backpressure/stall: word_valid held low for 10 cycles in LOAD -> word_ready stays 1, no shift_en, bit_count frozen. Resuming delivers the same head sequence as an unstalled run.
- Ignored start and stray valid: pulse start and word_valid during SHIFT -> no state change, word not consumed, shift count unaffected.
- Restart from DONE: start in DONE with CHAIN_LEN=8 and word 0x81 -> done drops next cycle, 8 shifts with head 10000001, tail check passes, done returns.
